// File: rtl/ex1_alu_pipe_pkg.sv
// ex1_alu_pipe_pkg
//   Shared definitions for the EX1 stage: ALU op encodings, source-select
//   encodings and the default datapath width.
package ex1_alu_pipe_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLT   = 4'd2,
    ALU_SLTU  = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_PASSB = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC1_RF   = 2'd0,
    SRC1_PC   = 2'd1,
    SRC1_ZERO = 2'd2
  } src1_sel_e;

  typedef enum logic [1:0] {
    SRC2_RF  = 2'd0,
    SRC2_IMM = 2'd1
  } src2_sel_e;

endpackage

// File: rtl/ex1_fwd_mux.sv
// ex1_fwd_mux
//   Resolves one source operand against the downstream forwarding network.
//   Priority: stage 0 (youngest) first, and within a stage the highest lane.
//   Ports:
//     idx      register index being read
//     dflt     regfile read data used when nothing matches
//     fwd_*    flattened forwarding vectors, entry k = stage*LANES + lane
//     data     resolved operand (0 for index 0)
//     hit      some downstream lane supplied the value
//     pending  the supplying lane's data is not final yet
module ex1_fwd_mux
  import ex1_alu_pipe_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int FWD_STAGES = 2,
  parameter int XLEN       = XLEN_DEF
) (
  input  logic [4:0]                        idx,
  input  logic [XLEN-1:0]                   dflt,
  input  logic [FWD_STAGES*LANES*5-1:0]     fwd_rd,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_we,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_ok,
  input  logic [FWD_STAGES*LANES*XLEN-1:0]  fwd_data,
  output logic [XLEN-1:0]                   data,
  output logic                              hit,
  output logic                              pending
);

  // Walk from lowest to highest priority so the last match written wins:
  // oldest stage first, and lanes in ascending order within a stage.
  always_comb begin
    data    = dflt;
    hit     = 1'b0;
    pending = 1'b0;
    for (int s = FWD_STAGES - 1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        if (fwd_we[s*LANES+l] && (fwd_rd[(s*LANES+l)*5 +: 5] == idx)) begin
          data    = fwd_data[(s*LANES+l)*XLEN +: XLEN];
          hit     = 1'b1;
          pending = ~fwd_ok[s*LANES+l];
        end
      end
    end
    // r0 is hardwired zero and can never be produced downstream.
    if (idx == 5'd0) begin
      data    = '0;
      hit     = 1'b0;
      pending = 1'b0;
    end
  end

endmodule

// File: rtl/ex1_alu_pipe.sv
// ex1_alu_pipe
//   First execute stage for an N-lane in-order bundle. Forwards rj/rk,
//   selects ALU sources, computes results and holds them in the EX1->EX2
//   register behind a valid/ready handshake with load-use stall and flush.
//   Ports:
//     clk, aresetn          clock, asynchronous active-low reset
//     flush                 kill held and incoming bundle
//     in_*                  issue bundle (flattened per lane), in_ready back
//     fwd_*                 downstream forwarding sources
//     out_*                 registered bundle towards EX2, out_ready in
//     stall_cnt             saturating count of hazard-stall cycles
module ex1_alu_pipe
  import ex1_alu_pipe_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int FWD_STAGES = 2,
  parameter int XLEN       = XLEN_DEF
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES-1:0]                  in_lane_en,
  input  logic [LANES*XLEN-1:0]             in_pc,
  input  logic [LANES*4-1:0]                in_op,
  input  logic [LANES*2-1:0]                in_src1_sel,
  input  logic [LANES*2-1:0]                in_src2_sel,
  input  logic [LANES*5-1:0]                in_rj,
  input  logic [LANES*5-1:0]                in_rk,
  input  logic [LANES*5-1:0]                in_rd,
  input  logic [LANES*XLEN-1:0]             in_rj_data,
  input  logic [LANES*XLEN-1:0]             in_rk_data,
  input  logic [LANES*XLEN-1:0]             in_imm,
  input  logic [FWD_STAGES*LANES*5-1:0]     fwd_rd,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_we,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_ok,
  input  logic [FWD_STAGES*LANES*XLEN-1:0]  fwd_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0]                  out_lane_en,
  output logic [LANES*5-1:0]                out_rd,
  output logic [LANES*XLEN-1:0]             out_result,
  output logic [LANES*XLEN-1:0]             out_rk_fwd,
  output logic [31:0]                       stall_cnt
);

  localparam int SHW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] alu(input logic [3:0] op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      ALU_ADD:   alu = a + b;
      ALU_SUB:   alu = a - b;
      ALU_SLT:   alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  alu = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_AND:   alu = a & b;
      ALU_OR:    alu = a | b;
      ALU_XOR:   alu = a ^ b;
      ALU_NOR:   alu = ~(a | b);
      ALU_SLL:   alu = a << sh;
      ALU_SRL:   alu = a >> sh;
      ALU_SRA:   alu = $signed(a) >>> sh;
      ALU_PASSB: alu = b;
      default:   alu = '0;
    endcase
  endfunction

  logic [LANES*XLEN-1:0] result_next;
  logic [LANES*XLEN-1:0] rk_next;
  logic [LANES-1:0]      lane_hazard;
  logic                  hazard;
  logic                  load;
  logic                  accept;
  logic                  stall_inc;

  logic                  valid_reg;
  logic [LANES-1:0]      lane_en_reg;
  logic [LANES*5-1:0]    rd_reg;
  logic [LANES*XLEN-1:0] result_reg;
  logic [LANES*XLEN-1:0] rk_reg;
  logic [31:0]           stall_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [XLEN-1:0] rj_val, rk_val, src_a, src_b;
      logic            rj_hit, rk_hit, rj_pend, rk_pend;

      ex1_fwd_mux #(
        .LANES(LANES), .FWD_STAGES(FWD_STAGES), .XLEN(XLEN)
      ) u_rj_mux (
        .idx(in_rj[gi*5 +: 5]), .dflt(in_rj_data[gi*XLEN +: XLEN]),
        .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_ok(fwd_ok), .fwd_data(fwd_data),
        .data(rj_val), .hit(rj_hit), .pending(rj_pend)
      );

      ex1_fwd_mux #(
        .LANES(LANES), .FWD_STAGES(FWD_STAGES), .XLEN(XLEN)
      ) u_rk_mux (
        .idx(in_rk[gi*5 +: 5]), .dflt(in_rk_data[gi*XLEN +: XLEN]),
        .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_ok(fwd_ok), .fwd_data(fwd_data),
        .data(rk_val), .hit(rk_hit), .pending(rk_pend)
      );

      always_comb begin
        case (in_src1_sel[gi*2 +: 2])
          SRC1_RF: src_a = rj_val;
          SRC1_PC: src_a = in_pc[gi*XLEN +: XLEN];
          default: src_a = '0;
        endcase
        src_b = (in_src2_sel[gi*2 +: 2] == SRC2_IMM) ? in_imm[gi*XLEN +: XLEN] : rk_val;
      end

      // rk is always consumed (store data), rj only when it feeds the ALU.
      assign lane_hazard[gi] = in_lane_en[gi] &
          (((in_src1_sel[gi*2 +: 2] == SRC1_RF) & rj_hit & rj_pend) | (rk_hit & rk_pend));

      assign result_next[gi*XLEN +: XLEN] = alu(in_op[gi*4 +: 4], src_a, src_b);
      assign rk_next[gi*XLEN +: XLEN]     = rk_val;
    end
  endgenerate

  assign hazard    = |lane_hazard;
  assign load      = ~valid_reg | out_ready;
  assign in_ready  = aresetn & load & ~hazard & ~flush;
  assign accept    = in_valid & in_ready;
  assign stall_inc = in_valid & hazard & load & ~flush;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_reg   <= 1'b0;
      lane_en_reg <= '0;
      rd_reg      <= '0;
      result_reg  <= '0;
      rk_reg      <= '0;
      stall_reg   <= '0;
    end else begin
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (load) begin
        valid_reg <= accept;
        if (accept) begin
          lane_en_reg <= in_lane_en;
          rd_reg      <= in_rd;
          result_reg  <= result_next;
          rk_reg      <= rk_next;
        end
      end
      if (stall_inc && (stall_reg != 32'hFFFF_FFFF)) begin
        stall_reg <= stall_reg + 32'd1;
      end
    end
  end

  assign out_valid   = valid_reg;
  assign out_lane_en = lane_en_reg;
  assign out_rd      = rd_reg;
  assign out_result  = result_reg;
  assign out_rk_fwd  = rk_reg;
  assign stall_cnt   = stall_reg;

endmodule

// File: tb/tb_ex1_alu_pipe.sv
// tb_ex1_alu_pipe
//   Table-driven ALU vectors, directed handshake/hazard/flush/reset
//   sequences and randomized traffic, all checked against a behavioural
//   model of the stage kept in this file.
module tb_ex1_alu_pipe;

  localparam int L = 2;
  localparam int F = 2;
  localparam int X = 32;

  logic             clk = 1'b0;
  logic             aresetn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [L-1:0]     in_lane_en;
  logic [L*X-1:0]   in_pc, in_rj_data, in_rk_data, in_imm;
  logic [L*4-1:0]   in_op;
  logic [L*2-1:0]   in_src1_sel, in_src2_sel;
  logic [L*5-1:0]   in_rj, in_rk, in_rd;
  logic [F*L*5-1:0] fwd_rd;
  logic [F*L-1:0]   fwd_we, fwd_ok;
  logic [F*L*X-1:0] fwd_data;
  logic             out_valid;
  logic             out_ready;
  logic [L-1:0]     out_lane_en;
  logic [L*5-1:0]   out_rd;
  logic [L*X-1:0]   out_result, out_rk_fwd;
  logic [31:0]      stall_cnt;

  always #5 clk = ~clk;

  ex1_alu_pipe #(.LANES(L), .FWD_STAGES(F), .XLEN(X)) dut (
    .clk(clk), .aresetn(aresetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_en(in_lane_en),
    .in_pc(in_pc), .in_op(in_op), .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
    .in_rj(in_rj), .in_rk(in_rk), .in_rd(in_rd),
    .in_rj_data(in_rj_data), .in_rk_data(in_rk_data), .in_imm(in_imm),
    .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_ok(fwd_ok), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en),
    .out_rd(out_rd), .out_result(out_result), .out_rk_fwd(out_rk_fwd),
    .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference state of the EX1->EX2 register.
  logic        m_valid;
  logic [L-1:0] m_en;
  logic [4:0]  m_rd  [L];
  logic [31:0] m_res [L];
  logic [31:0] m_rk  [L];
  logic [31:0] m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~(a | b);
      4'd8:    return a << sh;
      4'd9:    return a >> sh;
      4'd10:   return 32'($signed(a) >>> sh);
      4'd11:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // First match in priority order: youngest stage, then youngest lane.
  task automatic resolve(input logic [4:0] idx, input logic [31:0] dflt,
                         output logic [31:0] val, output logic pend);
    bit found;
    found = 0;
    val   = dflt;
    pend  = 0;
    if (idx == 5'd0) begin
      val = 0;
    end else begin
      for (int s = 0; s < F; s++) begin
        for (int l = L - 1; l >= 0; l--) begin
          if (!found && fwd_we[s*L+l] && fwd_rd[(s*L+l)*5 +: 5] == idx) begin
            val   = fwd_data[(s*L+l)*X +: X];
            pend  = !fwd_ok[s*L+l];
            found = 1;
          end
        end
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_en    = '0;
    m_stall = 0;
    for (int l = 0; l < L; l++) begin
      m_rd[l] = 0; m_res[l] = 0; m_rk[l] = 0;
    end
  endtask

  // One clock: predict, check in_ready, clock, update model, check outputs.
  task automatic cycle();
    logic [31:0] res [L];
    logic [31:0] rkv [L];
    logic [31:0] rjv, a, b;
    logic        pj, pk, hz, ld, ir, acc;
    #1;
    hz = 0;
    for (int l = 0; l < L; l++) begin
      resolve(in_rj[l*5 +: 5], in_rj_data[l*X +: X], rjv, pj);
      resolve(in_rk[l*5 +: 5], in_rk_data[l*X +: X], rkv[l], pk);
      case (in_src1_sel[l*2 +: 2])
        2'd0:    a = rjv;
        2'd1:    a = in_pc[l*X +: X];
        default: a = 0;
      endcase
      b = (in_src2_sel[l*2 +: 2] == 2'd1) ? in_imm[l*X +: X] : rkv[l];
      res[l] = ref_alu(in_op[l*4 +: 4], a, b);
      if (in_lane_en[l] && ((in_src1_sel[l*2 +: 2] == 2'd0 && pj) || pk)) hz = 1;
    end
    ld  = !m_valid || out_ready;
    ir  = ld && !hz && !flush;
    acc = in_valid && ir;
    chk("in_ready", {31'd0, in_ready}, {31'd0, ir});
    @(posedge clk);
    if (in_valid && hz && ld && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (flush) m_valid = 0;
    else if (ld) begin
      m_valid = acc;
      if (acc) begin
        m_en = in_lane_en;
        for (int l = 0; l < L; l++) begin
          m_rd[l] = in_rd[l*5 +: 5]; m_res[l] = res[l]; m_rk[l] = rkv[l];
        end
        $display("ACCEPT t=%0t en=%b res0=%h res1=%h", $time, in_lane_en, res[0], res[1]);
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("stall_cnt", stall_cnt, m_stall);
    if (m_valid) begin
      chk("out_lane_en", {30'd0, out_lane_en}, {30'd0, m_en});
      for (int l = 0; l < L; l++) begin
        chk("out_rd", {27'd0, out_rd[l*5 +: 5]}, {27'd0, m_rd[l]});
        if (m_en[l]) begin
          chk("out_result", out_result[l*X +: X], m_res[l]);
          chk("out_rk_fwd", out_rk_fwd[l*X +: X], m_rk[l]);
        end
      end
    end
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; in_lane_en = '0; in_pc = '0; in_op = '0;
    in_src1_sel = '0; in_src2_sel = '0; in_rj = '0; in_rk = '0; in_rd = '0;
    in_rj_data = '0; in_rk_data = '0; in_imm = '0;
    fwd_rd = '0; fwd_we = '0; fwd_ok = '0; fwd_data = '0;
  endtask

  task automatic set_lane(input int l, input logic en, input logic [3:0] op,
                          input logic [1:0] s1, input logic [1:0] s2,
                          input logic [4:0] rj, input logic [31:0] rjd,
                          input logic [4:0] rk, input logic [31:0] rkd,
                          input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] pc);
    in_lane_en[l] = en;
    in_op[l*4 +: 4] = op;
    in_src1_sel[l*2 +: 2] = s1;
    in_src2_sel[l*2 +: 2] = s2;
    in_rj[l*5 +: 5] = rj; in_rj_data[l*X +: X] = rjd;
    in_rk[l*5 +: 5] = rk; in_rk_data[l*X +: X] = rkd;
    in_imm[l*X +: X] = imm; in_rd[l*5 +: 5] = rd; in_pc[l*X +: X] = pc;
  endtask

  task automatic set_fwd(input int s, input int l, input logic we, input logic ok,
                         input logic [4:0] rd, input logic [31:0] data);
    fwd_we[s*L+l] = we; fwd_ok[s*L+l] = ok;
    fwd_rd[(s*L+l)*5 +: 5] = rd; fwd_data[(s*L+l)*X +: X] = data;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{4'd0,  32'd5,          32'd7,          32'd12};
    vecs[1]  = '{4'd1,  32'd10,         32'd3,          32'd7};
    vecs[2]  = '{4'd2,  32'hFFFF_FFFF,  32'd1,          32'd1};
    vecs[3]  = '{4'd3,  32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[4]  = '{4'd4,  32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234};
    vecs[5]  = '{4'd5,  32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
    vecs[6]  = '{4'd6,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F};
    vecs[7]  = '{4'd7,  32'hF0F0_0000,  32'h0000_0F0F,  32'h0F0F_F0F0};
    vecs[8]  = '{4'd8,  32'h0000_0003,  32'h0000_0024,  32'h0000_0030};
    vecs[9]  = '{4'd9,  32'h8000_0000,  32'd4,          32'h0800_0000};
    vecs[10] = '{4'd10, 32'h8000_0000,  32'd4,          32'hF800_0000};
    vecs[11] = '{4'd11, 32'd5,          32'hDEAD_BEEF,  32'hDEAD_BEEF};
    vecs[12] = '{4'd12, 32'd5,          32'd7,          32'd0};
    vecs[13] = '{4'd15, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0};
    vecs[14] = '{4'd1,  32'd0,          32'd1,          32'hFFFF_FFFF};
    vecs[15] = '{4'd0,  32'hFFFF_FFFF,  32'd2,          32'd1};

    clear_inputs();
    out_ready = 1;
    aresetn   = 0;
    model_reset();
    in_valid = 1;
    in_lane_en = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_lane_en", {30'd0, out_lane_en}, 32'd0);
    chk("rst_result", out_result[31:0], 32'd0);
    chk("rst_rk_fwd", out_rk_fwd[63:32], 32'd0);
    chk("rst_rd", {22'd0, out_rd}, 32'd0);
    clear_inputs();
    @(negedge clk);
    aresetn = 1;

    // Basic two-lane bundle.
    set_lane(0, 1, 4'd0, 2'd0, 2'd0, 5'd1, 32'd5,  5'd2, 32'd7, 32'd0, 5'd3, 32'h0);
    set_lane(1, 1, 4'd1, 2'd0, 2'd1, 5'd4, 32'd10, 5'd5, 32'd9, 32'd3, 5'd6, 32'h4);
    in_valid = 1;
    cycle();
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_res0", out_result[31:0], 32'd12);
    chk("basic_res1", out_result[63:32], 32'd7);
    chk("basic_rd0", {27'd0, out_rd[4:0]}, 32'd3);

    // Forwarding priority: stage 0 before stage 1, highest lane in a stage.
    clear_inputs();
    set_fwd(0, 1, 1, 1, 5'd1, 32'h100);
    set_fwd(1, 0, 1, 1, 5'd1, 32'h200);
    set_lane(0, 1, 4'd0, 2'd0, 2'd1, 5'd1, 32'h55, 5'd0, 32'd0, 32'd0, 5'd7, 32'h0);
    set_lane(1, 1, 4'd0, 2'd1, 2'd1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd4, 5'd8, 32'h1000);
    in_valid = 1;
    cycle();
    chk("fwd_stage0", out_result[31:0], 32'h100);
    chk("src1_pc", out_result[63:32], 32'h1004);
    set_fwd(0, 1, 0, 1, 5'd1, 32'h100);
    cycle();
    chk("fwd_stage1", out_result[31:0], 32'h200);
    set_fwd(0, 0, 1, 1, 5'd1, 32'h300);
    set_fwd(0, 1, 1, 1, 5'd1, 32'h100);
    cycle();
    chk("fwd_lane_prio", out_result[31:0], 32'h100);
    // r0 reads zero even when a downstream lane claims rd=0.
    set_fwd(0, 0, 1, 1, 5'd0, 32'hABCD);
    set_fwd(0, 1, 1, 1, 5'd0, 32'hABCD);
    set_lane(0, 1, 4'd0, 2'd0, 2'd1, 5'd0, 32'h55, 5'd0, 32'h66, 32'd0, 5'd7, 32'h0);
    cycle();
    chk("r0_zero", out_result[31:0], 32'd0);
    chk("r0_rk_zero", out_rk_fwd[31:0], 32'd0);

    // Load-use hazard on rk: three stall cycles, then accept.
    clear_inputs();
    set_fwd(0, 0, 1, 0, 5'd2, 32'h2222);
    set_lane(0, 1, 4'd0, 2'd0, 2'd0, 5'd1, 32'd1, 5'd2, 32'd9, 32'd0, 5'd3, 32'h0);
    in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("hz_valid", {31'd0, out_valid}, 32'd0);
      chk("hz_stall", stall_cnt, i);
    end
    set_fwd(0, 0, 1, 1, 5'd2, 32'h2222);
    cycle();
    chk("hz_release", {31'd0, out_valid}, 32'd1);
    chk("hz_result", out_result[31:0], 32'h2223);
    chk("hz_rk_fwd", out_rk_fwd[31:0], 32'h2222);
    // Pending rj is harmless when src1 is not RF.
    set_fwd(0, 0, 1, 0, 5'd5, 32'h0);
    set_lane(0, 1, 4'd0, 2'd1, 2'd1, 5'd5, 32'd0, 5'd0, 32'd0, 32'd8, 5'd3, 32'h40);
    cycle();
    chk("pc_no_hz", out_result[31:0], 32'h48);

    // Backpressure: hold for four cycles, then capture the waiting bundle.
    clear_inputs();
    out_ready = 0;
    set_lane(0, 1, 4'd6, 2'd0, 2'd1, 5'd1, 32'hFF, 5'd0, 32'd0, 32'h0F, 5'd9, 32'h0);
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("hold_result", out_result[31:0], 32'h48);
    end
    out_ready = 1;
    cycle();
    chk("hold_release", out_result[31:0], 32'hF0);

    // Flush with a held bundle and an incoming bundle.
    out_ready = 0;
    set_lane(0, 1, 4'd0, 2'd0, 2'd1, 5'd1, 32'h1, 5'd0, 32'd0, 32'h1, 5'd9, 32'h0);
    cycle();
    chk("pre_flush", {31'd0, out_valid}, 32'd1);
    flush = 1;
    cycle();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 0; in_valid = 0; out_ready = 1;
    cycle();
    chk("post_flush", {31'd0, out_valid}, 32'd0);

    // Reset during a stall clears everything at once.
    clear_inputs();
    set_fwd(1, 1, 1, 0, 5'd4, 32'h0);
    set_lane(1, 1, 4'd0, 2'd0, 2'd0, 5'd4, 32'd0, 5'd0, 32'd0, 32'd0, 5'd1, 32'h0);
    in_valid = 1;
    cycle();
    cycle();
    chk("mid_stall", stall_cnt, 32'd5);
    #2;
    aresetn = 0;
    #1;
    chk("arst_stall", stall_cnt, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    model_reset();
    clear_inputs();
    #1;
    aresetn = 1;

    // ALU vector table on lane 0.
    for (int i = 0; i < 16; i++) begin
      clear_inputs();
      set_lane(0, 1, vecs[i].op, 2'd0, 2'd0, 5'd1, vecs[i].a, 5'd2, vecs[i].b, 32'd0, 5'd1, 32'h0);
      in_valid = 1;
      cycle();
      chk("alu_vec", out_result[31:0], vecs[i].exp);
      $display("VEC %0d op=%0d a=%h b=%h res=%h", i, vecs[i].op, vecs[i].a, vecs[i].b, out_result[31:0]);
    end

    // Randomized traffic with a small register space to provoke matches.
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      for (int l = 0; l < L; l++) begin
        set_lane(l, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 2)), 2'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                 $urandom, 5'($urandom_range(0, 31)), $urandom);
      end
      for (int s = 0; s < F; s++)
        for (int l = 0; l < L; l++)
          set_fwd(s, l, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 3)), $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
